// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the fixed-period PWM block.
package pwm_pkg;

  localparam int W_DEF = 4;

  // Cycles per PWM period for a w-bit duty code; all-ones code means always high.
  function automatic int period(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_counter.sv
// Phase counter for the PWM: counts 0..PERIOD-1 and wraps, strobing at phase 0.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(period(W) - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == '0);

endmodule

// File: rtl/pwm.sv
// Fixed-period PWM: duty code shadowed at each period start, registered output.
module pwm
  import pwm_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] Input,
  output logic         OUT
);

  localparam int PERIOD = period(W);

  logic [W-1:0] cnt;
  logic         wrap;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] duty_use;
  logic         out_q, out_d;

  pwm_counter #(.W(W)) u_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  // At phase 0 the fresh code drives the compare directly so the new duty
  // applies to this very period; elsewhere the shadow keeps the period glitch-free.
  always_comb begin
    duty_use = wrap ? Input : duty_q;
    duty_d   = duty_use;
    out_d    = (cnt < duty_use);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      duty_q <= '0;
      out_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      out_q  <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_pwm.sv
// Directed self-checking bench for pwm (W=4, 15-cycle period).
module tb_pwm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] Input = 4'd0;
  logic       OUT;

  int n_cmp = 0;
  int n_err = 0;

  pwm dut (
    .CLK   (CLK),
    .RST   (RST),
    .Input (Input),
    .OUT   (OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one posedge, then sample OUT 1 ns later.
  task automatic step_chk(input string tag, input logic exp);
    @(posedge CLK);
    #1;
    check(tag, {3'b0, OUT}, {3'b0, exp});
  endtask

  initial begin
    // T1: reset held for 100 ns with Input=0
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      check("t1_out", {3'b0, OUT}, 4'd0);
      check("t1_cnt", dut.cnt, 4'd0);
    end

    // T2: release with full-on code; high from the very first edge
    RST   = 1'b0;
    Input = 4'd15;
    for (int i = 0; i < 45; i++) step_chk("t2_full_on", 1'b1);

    // Three full periods consumed: counter is back at phase 0
    check("t2_cnt_wrap", dut.cnt, 4'd0);

    // T3: full off
    Input = 4'd0;
    for (int i = 0; i < 45; i++) step_chk("t3_full_off", 1'b0);

    // T4: half duty, 8 high then 7 low per period
    Input = 4'd8;
    for (int i = 0; i < 30; i++) step_chk("t4_half", (i % 15) < 8);

    // T5: code 3, switched to 12 once cnt reaches 5
    Input = 4'd3;
    for (int i = 0; i < 5; i++) step_chk("t5_first", i < 3);
    check("t5_cnt5", dut.cnt, 4'd5);
    Input = 4'd12;
    for (int i = 5; i < 15; i++) step_chk("t5_first", i < 3);
    for (int i = 0; i < 15; i++) step_chk("t5_next", i < 12);

    // T6: code 10, reset pulse with cnt=7
    Input = 4'd10;
    for (int i = 0; i < 7; i++) step_chk("t6_pre", i < 10);
    check("t6_cnt7", dut.cnt, 4'd7);
    RST = 1'b1;
    step_chk("t6_rst_edge", 1'b0);
    check("t6_rst_cnt", dut.cnt, 4'd0);
    RST = 1'b0;
    for (int i = 0; i < 15; i++) step_chk("t6_fresh", i < 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
